// File: rtl/mips_trace_capture_pkg.sv
// Shared types and entry layout for the MIPS debug-port trace capture block.
package mips_trace_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  localparam int unsigned DEF_DEPTH = 16;
  localparam int unsigned DEF_AW    = 4;
  localparam int unsigned DEF_SW    = 16;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned DATA_W = 32;

  // Entry layout, MSB to LSB: {pc, data, stamp}
  localparam int unsigned STAMP_LSB = 0;

  function automatic int unsigned entry_w(input int unsigned sw);
    return PC_W + DATA_W + sw;
  endfunction

  function automatic int unsigned data_lsb(input int unsigned sw);
    return sw;
  endfunction

  function automatic int unsigned pc_lsb(input int unsigned sw);
    return sw + DATA_W;
  endfunction

  localparam int unsigned ENTRY_W = PC_W + DATA_W + DEF_SW;

endpackage

// File: rtl/mips_trace_capture_if.sv
// Host read port of the trace capture block: valid/ready entry stream.
interface mips_trace_capture_if #(
  parameter int unsigned SW = 16
) ();

  logic          RD_VALID;
  logic          RD_READY;
  logic [31:0]   RD_PC;
  logic [31:0]   RD_DATA;
  logic [SW-1:0] RD_STAMP;

  modport master (
    output RD_VALID,
    output RD_PC,
    output RD_DATA,
    output RD_STAMP,
    input  RD_READY
  );

  modport slave (
    input  RD_VALID,
    input  RD_PC,
    input  RD_DATA,
    input  RD_STAMP,
    output RD_READY
  );

endinterface

// File: rtl/mips_trace_capture_trace_buffer.sv
// Trace entry storage: synchronous write, asynchronous read, no reset on contents.
module trace_buffer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned EW    = 80
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [EW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [EW-1:0] rdata
);

  logic [EW-1:0] mem [DEPTH];

  // Write one entry per enabled cycle
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mips_trace_capture.sv
// Debug-port trace capture: arm, trigger on PC match, record a window of
// PC/Result/stamp entries, then let the host drain them over a valid/ready port.
module mips_trace_capture
  import mips_trace_capture_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = DEF_AW,
  parameter int unsigned SW    = DEF_SW
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [31:0]          ADDRESS,
  input  logic [31:0]          DATA,
  input  logic [31:0]          TRIG_PC,
  input  logic                 ARM,
  mips_trace_capture_if.master rd,
  output logic [AW:0]          COUNT,
  output logic [31:0]          TRIG_WAIT,
  output logic                 HALTED,
  output logic [1:0]           STATE
);

  localparam int unsigned EW      = entry_w(SW);
  localparam int unsigned PC_LSB  = pc_lsb(SW);
  localparam int unsigned DAT_LSB = data_lsb(SW);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW + 1)'(1);

  state_t        state_q;
  logic [AW:0]   count_q;
  logic [AW:0]   rd_ptr_q;
  logic [31:0]   trig_wait_q;
  logic [SW-1:0] stamp_q;
  logic          halted_q;
  logic [31:0]   prev_addr_q;

  logic          match;
  logic          self_jump;
  logic          arm_restart;
  logic          wr_en;
  logic [SW-1:0] wr_stamp;
  logic [EW-1:0] wr_data;
  logic [EW-1:0] rd_entry;
  logic          rd_valid;
  logic          rd_xfer;

  assign match       = (ADDRESS == TRIG_PC);
  assign self_jump   = (ADDRESS == prev_addr_q);
  // ARM restarts from any state except DRAIN, and beats a same-cycle trigger
  assign arm_restart = ARM && (state_q != ST_DRAIN);
  assign wr_en       = !ARM && (((state_q == ST_ARMED) && match) ||
                                ((state_q == ST_CAPTURE) && !self_jump));
  // The trigger entry is stamped 0; stamp_q already holds 1 on the next cycle
  assign wr_stamp    = (state_q == ST_ARMED) ? '0 : stamp_q;
  assign wr_data     = {ADDRESS, DATA, wr_stamp};

  assign rd_valid = (state_q == ST_DRAIN) && (rd_ptr_q < count_q);
  assign rd_xfer  = rd_valid && rd.RD_READY;

  trace_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .EW    (EW)
  ) u_buffer (
    .CLK   (CLK),
    .we    (wr_en),
    .waddr (count_q[AW-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rd_entry)
  );

  // Previous-cycle PC for self-jump halt detection
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      prev_addr_q <= '0;
    end else begin
      prev_addr_q <= ADDRESS;
    end
  end

  // Capture FSM with trigger-wait, stamp, count and read-pointer bookkeeping
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      trig_wait_q <= '0;
      stamp_q     <= '0;
      halted_q    <= 1'b0;
    end else if (arm_restart) begin
      state_q     <= ST_ARMED;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      trig_wait_q <= '0;
      stamp_q     <= '0;
      halted_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_ARMED: begin
          if (trig_wait_q != '1) begin
            trig_wait_q <= trig_wait_q + 32'd1;
          end
          if (match) begin
            count_q <= ONE_C;
            stamp_q <= SW'(1);
            state_q <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (stamp_q != '1) begin
            stamp_q <= stamp_q + SW'(1);
          end
          if (self_jump) begin
            halted_q <= 1'b1;
            state_q  <= ST_DRAIN;
          end else begin
            count_q <= count_q + ONE_C;
            if ((count_q + ONE_C) == DEPTH_C) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (!rd_valid) begin
            state_q <= ST_IDLE;
          end else if (rd_xfer) begin
            rd_ptr_q <= rd_ptr_q + ONE_C;
            if ((rd_ptr_q + ONE_C) == count_q) begin
              state_q <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  // Read port: entries shown straight from storage, zero when nothing is offered
  always_comb begin
    rd.RD_VALID = rd_valid;
    rd.RD_PC    = '0;
    rd.RD_DATA  = '0;
    rd.RD_STAMP = '0;
    if (rd_valid) begin
      rd.RD_PC    = rd_entry[PC_LSB +: 32];
      rd.RD_DATA  = rd_entry[DAT_LSB +: 32];
      rd.RD_STAMP = rd_entry[STAMP_LSB +: SW];
    end
  end

  assign COUNT     = count_q;
  assign TRIG_WAIT = trig_wait_q;
  assign HALTED    = halted_q;
  assign STATE     = state_q;

endmodule
